// File: rtl/tcdm_banked_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_banked_mem_model
// Brief    : Multi-port, word-interleaved TCDM memory model with per-bank
//            round-robin arbitration and fixed-latency response pipelines.
//            Optional LFSR stall injection when TCDM_MODEL_STALL_EN is defined.
// Revision : 1.0
// ============================================================================
module tcdm_banked_mem_model #(
    parameter int          MP           = 5,
    parameter int          N_BANKS      = 4,
    parameter int          MEMORY_SIZE  = 262144,
    parameter int          LATENCY      = 1,
    parameter logic [7:0]  STALL_THRESH = 8'd26,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 randomize_i,
    input  logic                 stallable_i,
    input  logic [MP-1:0]        tcdm_req,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0][31:0]  tcdm_data,
    input  logic [MP-1:0][3:0]   tcdm_be,
    output logic [MP-1:0]        tcdm_gnt,
    output logic [MP-1:0]        tcdm_r_valid,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0][31:0]  cnt_rd_o,
    output logic [MP-1:0][31:0]  cnt_wr_o
);

    localparam int c_WORDS  = MEMORY_SIZE / 4;
    localparam int c_IDX_W  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int c_PTR_W  = (MP > 1) ? $clog2(MP) : 1;
    localparam logic [c_BANK_W-1:0] c_BANK_MASK = c_BANK_W'(N_BANKS - 1);

    logic [31:0]         memory    [c_WORDS];
    logic [c_IDX_W-1:0]  w_idx     [MP];
    logic [c_BANK_W-1:0] w_bank    [MP];
    logic [MP-1:0]       w_stall;
    logic [MP-1:0]       w_elig;
    logic [MP-1:0]       w_gnt;
    logic [c_PTR_W-1:0]  r_ptr     [N_BANKS];
    logic [c_PTR_W-1:0]  w_ptr_nxt [N_BANKS];
    logic                r_vpipe   [MP][LATENCY];
    logic [31:0]         r_dpipe   [MP][LATENCY];
    logic [31:0]         r_cnt_rd  [MP];
    logic [31:0]         r_cnt_wr  [MP];
    logic                w_unused;

    // The flat word index equals row*N_BANKS+bank, so wrapping it also wraps the row.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_idx[p]  = c_IDX_W'(tcdm_add[p][31:2] % 30'(c_WORDS));
            w_bank[p] = tcdm_add[p][2 +: c_BANK_W] & c_BANK_MASK;
            w_elig[p] = tcdm_req[p] & enable_i & ~rst_i & ~w_stall[p];
        end
    end

`ifdef TCDM_MODEL_STALL_EN
    logic [15:0] r_lfsr [MP];

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (rst_i) begin
                r_lfsr[p] <= SEED + 16'(p);
            end else begin
                r_lfsr[p] <= {r_lfsr[p][14:0],
                              r_lfsr[p][15] ^ r_lfsr[p][13] ^ r_lfsr[p][12] ^ r_lfsr[p][10]};
            end
        end
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_stall[p] = randomize_i & stallable_i & (r_lfsr[p][7:0] < STALL_THRESH);
        end
    end
`else
    assign w_stall = '0;
`endif

    always_comb begin
        w_unused = 1'b0;
        for (int p = 0; p < MP; p++) begin
            w_unused = w_unused ^ (^tcdm_add[p][1:0]);
        end
`ifndef TCDM_MODEL_STALL_EN
        w_unused = w_unused ^ randomize_i ^ stallable_i;
`endif
    end

    // Per-bank search starts at the pointer and takes the first eligible port.
    always_comb begin
        logic found;
        found = 1'b0;
        w_gnt = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_ptr_nxt[b] = r_ptr[b];
            found        = 1'b0;
            for (int off = 0; off < MP; off++) begin
                for (int q = 0; q < MP; q++) begin
                    if (!found && (q == (int'(r_ptr[b]) + off) % MP) && w_elig[q]
                        && (w_bank[q] == c_BANK_W'(b))) begin
                        found        = 1'b1;
                        w_gnt[q]     = 1'b1;
                        w_ptr_nxt[b] = c_PTR_W'((q + 1) % MP);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (w_gnt[p] && !tcdm_wen[p]) begin
                for (int k = 0; k < 4; k++) begin
                    if (tcdm_be[p][k]) begin
                        memory[w_idx[p]][8*k +: 8] <= tcdm_data[p][8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_ptr[b] <= '0;
            end
            for (int p = 0; p < MP; p++) begin
                for (int s = 0; s < LATENCY; s++) begin
                    r_vpipe[p][s] <= 1'b0;
                    r_dpipe[p][s] <= 32'h0;
                end
                r_cnt_rd[p] <= 32'h0;
                r_cnt_wr[p] <= 32'h0;
            end
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_ptr[b] <= w_ptr_nxt[b];
            end
            for (int p = 0; p < MP; p++) begin
                for (int s = LATENCY - 1; s > 0; s--) begin
                    r_vpipe[p][s] <= r_vpipe[p][s-1];
                    r_dpipe[p][s] <= r_dpipe[p][s-1];
                end
                r_vpipe[p][0] <= w_gnt[p];
                r_dpipe[p][0] <= (w_gnt[p] && tcdm_wen[p]) ? memory[w_idx[p]] : 32'h0;
                if (w_gnt[p] && tcdm_wen[p] && (r_cnt_rd[p] != 32'hFFFF_FFFF)) begin
                    r_cnt_rd[p] <= r_cnt_rd[p] + 32'd1;
                end
                if (w_gnt[p] && !tcdm_wen[p] && (r_cnt_wr[p] != 32'hFFFF_FFFF)) begin
                    r_cnt_wr[p] <= r_cnt_wr[p] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        tcdm_gnt = w_gnt;
        for (int p = 0; p < MP; p++) begin
            tcdm_r_valid[p] = r_vpipe[p][LATENCY-1];
            tcdm_r_data[p]  = r_dpipe[p][LATENCY-1];
            cnt_rd_o[p]     = r_cnt_rd[p];
            cnt_wr_o[p]     = r_cnt_wr[p];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_banked_mem_model.sv
`default_nettype none
// Bench for tcdm_banked_mem_model: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_tcdm_banked_mem_model;
    localparam int MP    = 5;
    localparam int NB    = 4;
    localparam int MEM   = 4096;
    localparam int LAT   = 3;
    localparam int WORDS = MEM / 4;
    localparam int RING  = 16;

    logic                clk = 1'b0;
    logic                rst, enable, rnd, stallable;
    logic [MP-1:0]       req, wen;
    logic [MP-1:0][31:0] add, wdata;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0]       gnt, rvalid;
    logic [MP-1:0][31:0] rdata, cnt_rd, cnt_wr;

    always #5 clk = ~clk;

    tcdm_banked_mem_model #(
        .MP(MP), .N_BANKS(NB), .MEMORY_SIZE(MEM), .LATENCY(LAT),
        .STALL_THRESH(8'd26), .SEED(16'hACE1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .randomize_i(rnd),
        .stallable_i(stallable), .tcdm_req(req), .tcdm_wen(wen), .tcdm_add(add),
        .tcdm_data(wdata), .tcdm_be(be), .tcdm_gnt(gnt), .tcdm_r_valid(rvalid),
        .tcdm_r_data(rdata), .cnt_rd_o(cnt_rd), .cnt_wr_o(cnt_wr)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] mmem [WORDS];
    int          rr [NB];
    bit          ev [MP][RING];
    logic [31:0] ed [MP][RING];
    int          mcnt_rd [MP];
    int          mcnt_wr [MP];
    logic [MP-1:0] e_gnt, e_rv;
    logic [31:0] e_rd [MP];

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % WORDS;
    endfunction

    function automatic int bank_of(input logic [31:0] a);
        return int'(a[31:2]) % NB;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        for (int q = 0; q < MP; q++) begin
            mcnt_rd[q] = 0;
            mcnt_wr[q] = 0;
            for (int s = 0; s < RING; s++) begin
                ev[q][s] = 1'b0;
                ed[q][s] = 32'h0;
            end
        end
    endtask

    // One request cycle: round-robin winners per bank, response due LAT cycles later.
    task automatic model_step();
        int s_now, s_fut, p, ix;
        bit found;
        s_now = cyc % RING;
        s_fut = (cyc + LAT) % RING;
        e_gnt = '0;
        for (int b = 0; b < NB; b++) begin
            found = 1'b0;
            if (enable) begin
                for (int off = 0; off < MP; off++) begin
                    p = (rr[b] + off) % MP;
                    if (!found && req[p] && bank_of(add[p]) == b) begin
                        found    = 1'b1;
                        e_gnt[p] = 1'b1;
                    end
                end
                for (int q = 0; q < MP; q++) if (e_gnt[q] && bank_of(add[q]) == b) rr[b] = (q + 1) % MP;
            end
        end
        for (int q = 0; q < MP; q++) begin
            e_rv[q] = ev[q][s_now];
            e_rd[q] = ed[q][s_now];
            ev[q][s_now] = 1'b0;
            ed[q][s_now] = 32'h0;
        end
        for (int q = 0; q < MP; q++) begin
            if (e_gnt[q]) begin
                ev[q][s_fut] = 1'b1;
                ed[q][s_fut] = wen[q] ? mmem[widx(add[q])] : 32'h0;
                if (wen[q]) mcnt_rd[q]++; else mcnt_wr[q]++;
            end
        end
        for (int q = 0; q < MP; q++) begin
            if (e_gnt[q] && !wen[q]) begin
                ix = widx(add[q]);
                for (int k = 0; k < 4; k++) if (be[q][k]) mmem[ix][8*k +: 8] = wdata[q][8*k +: 8];
            end
        end
        cyc++;
    endtask

    task automatic eval();
        @(negedge clk);
        model_step();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_clear();
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
        req[p]   = r;
        wen[p]   = w;
        add[p]   = a;
        wdata[p] = d;
        be[p]    = b;
    endtask

    task automatic test_reset();
        eval();
        n_vec++;
        if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        n_vec++;
        if (rvalid !== '0) begin n_err++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
        for (int q = 0; q < MP; q++) begin
            n_vec++;
            if (rdata[q] !== 32'h0 || cnt_rd[q] !== 32'h0 || cnt_wr[q] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_port%0d rdata=%h rd=%0d wr=%0d want all 0", q, rdata[q], cnt_rd[q], cnt_wr[q]);
            end
        end
        next();
    endtask

    task automatic fill_memory();
        for (int k = 0; k < WORDS / NB; k++) begin
            for (int q = 0; q < NB; q++) set_port(q, 1'b1, 1'b0, 32'((k * NB + q) * 4), $urandom, 4'hF);
            eval();
            n_vec++;
            if (gnt !== 5'b01111) begin n_err++; $display("FAIL fill_gnt row=%0d got=%b want=01111", k, gnt); end
            next();
        end
        req = '0;
        repeat (LAT + 1) begin eval(); next(); end
    endtask

    task automatic test_write_read();
        set_port(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
        eval();
        n_vec++;
        if (gnt[0] !== 1'b1) begin n_err++; $display("FAIL wr_gnt got=%b want=1", gnt[0]); end
        next();
        set_port(0, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0);
        eval();
        n_vec++;
        if (gnt[0] !== 1'b1) begin n_err++; $display("FAIL rd_gnt got=%b want=1", gnt[0]); end
        next();
        req = '0;
        for (int k = 1; k <= LAT + 1; k++) begin
            eval();
            n_vec++;
            if (rvalid[0] !== (k == LAT || k == LAT - 1)) begin
                n_err++; $display("FAIL wr_rd_rvalid k=%0d got=%b", k, rvalid[0]);
            end
            n_vec++;
            if (rdata[0] !== ((k == LAT) ? 32'hDEADBEEF : 32'h0)) begin
                n_err++; $display("FAIL wr_rd_rdata k=%0d got=%h", k, rdata[0]);
            end
            next();
        end
    endtask

    task automatic test_byte_enable();
        set_port(1, 1'b1, 1'b0, 32'h200, 32'hFFFFFFFF, 4'hF);
        eval(); next();
        set_port(1, 1'b1, 1'b0, 32'h200, 32'h11223344, 4'b0101);
        eval(); next();
        set_port(1, 1'b1, 1'b1, 32'h200, 32'h0, 4'h0);
        eval(); next();
        req = '0;
        for (int k = 1; k <= LAT; k++) begin
            eval();
            n_vec++;
            if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL be_rvalid k=%0d got=%b want=1", k, rvalid[1]); end
            n_vec++;
            if (rdata[1] !== ((k == LAT) ? 32'hFF22FF44 : 32'h0)) begin
                n_err++; $display("FAIL be_rdata k=%0d got=%h", k, rdata[1]);
            end
            next();
        end
    endtask

    task automatic test_round_robin();
        logic [MP-1:0] want;
        apply_reset();
        set_port(0, 1'b1, 1'b1, 32'h00, 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        set_port(2, 1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            want = '0;
            want[i % 3] = 1'b1;
            eval();
            n_vec++;
            if (gnt !== want) begin n_err++; $display("FAIL rr_gnt i=%0d got=%b want=%b", i, gnt, want); end
            next();
        end
        req = '0;
        repeat (LAT) begin eval(); next(); end
    endtask

    task automatic test_parallel_banks();
        for (int q = 0; q < 4; q++) set_port(q, 1'b1, 1'b1, 32'(q * 4), 32'h0, 4'h0);
        eval();
        n_vec++;
        if (gnt !== 5'b01111) begin n_err++; $display("FAIL par_gnt got=%b want=01111", gnt); end
        next();
        req = '0;
        repeat (LAT) begin eval(); next(); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400 + LAT + 1; i++) begin
            if (i < 400) begin
                enable = ($urandom_range(0, 9) != 0);
                for (int q = 0; q < MP; q++) begin
                    set_port(q, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                             32'($urandom_range(0, 3) * MEM + $urandom_range(0, 31) * 4 + $urandom_range(0, 3)),
                             $urandom, 4'($urandom_range(0, 15)));
                end
            end else begin
                enable = 1'b1;
                req    = '0;
            end
            eval();
            n_vec++;
            if (gnt !== e_gnt) begin n_err++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", i, gnt, e_gnt); end
            for (int q = 0; q < MP; q++) begin
                n_vec++;
                if (rvalid[q] !== e_rv[q] || rdata[q] !== e_rd[q]) begin
                    n_err++;
                    $display("FAIL rand_resp cyc=%0d port=%0d got=%b/%h want=%b/%h", i, q, rvalid[q], rdata[q], e_rv[q], e_rd[q]);
                end
            end
            next();
        end
        for (int q = 0; q < MP; q++) begin
            n_vec++;
            if (cnt_rd[q] !== 32'(mcnt_rd[q]) || cnt_wr[q] !== 32'(mcnt_wr[q])) begin
                n_err++;
                $display("FAIL rand_cnt port=%0d got rd=%0d wr=%0d want rd=%0d wr=%0d", q, cnt_rd[q], cnt_wr[q], mcnt_rd[q], mcnt_wr[q]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        set_port(0, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 4'hF);
        eval();
        n_vec++;
        if (gnt[0] !== 1'b1) begin n_err++; $display("FAIL mid_gnt got=%b want=1", gnt[0]); end
        next();
        apply_reset();
        for (int k = 0; k < LAT + 2; k++) begin
            eval();
            n_vec++;
            if (rvalid !== '0) begin n_err++; $display("FAIL mid_rvalid k=%0d got=%b want=0", k, rvalid); end
            next();
        end
        for (int q = 0; q < MP; q++) begin
            n_vec++;
            if (cnt_rd[q] !== 32'h0 || cnt_wr[q] !== 32'h0) begin
                n_err++; $display("FAIL mid_cnt port=%0d rd=%0d wr=%0d want 0", q, cnt_rd[q], cnt_wr[q]);
            end
        end
        set_port(0, 1'b1, 1'b1, 32'h300, 32'h0, 4'h0);
        eval(); next();
        req = '0;
        for (int k = 1; k <= LAT; k++) begin
            eval();
            if (k == LAT) begin
                n_vec++;
                if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hCAFEF00D) begin
                    n_err++; $display("FAIL mid_mem got=%b/%h want=1/cafef00d", rvalid[0], rdata[0]);
                end
            end
            next();
        end
    endtask

    task automatic test_stall();
        int miss;
        apply_reset();
        rnd       = 1'b1;
        stallable = 1'b1;
        set_port(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
`ifdef TCDM_MODEL_STALL_EN
        miss = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (gnt[0] !== 1'b1) miss++;
            next();
        end
        n_vec++;
        if (miss < 800 || miss > 1200) begin n_err++; $display("FAIL stall_frac got=%0d want 800..1200", miss); end
        rnd = 1'b0;
`endif
        miss = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gnt[0] !== 1'b1) miss++;
            next();
        end
        n_vec++;
        if (miss != 0) begin n_err++; $display("FAIL stall_none got=%0d want=0", miss); end
        rnd       = 1'b0;
        stallable = 1'b0;
        apply_reset();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; rnd = 1'b0; stallable = 1'b0;
        req = '0; wen = '0; add = '0; wdata = '0; be = '0;
        for (int i = 0; i < WORDS; i++) mmem[i] = 32'h0;
        model_clear();
        @(posedge clk);
        #1;
        apply_reset();
        test_reset();
        fill_memory();
        test_write_read();
        test_byte_enable();
        test_round_robin();
        test_parallel_banks();
        test_random();
        test_reset_midflight();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tcdm_banked_mem_model.md
TCDM_BANKED_MEM_MODEL -- requirements
Module: tcdm_banked_mem_model

Interface
REQ-001 SHALL have parameter MP, default 5, number of TCDM master ports.
REQ-002 SHALL have parameter N_BANKS, default 4, number of word-interleaved banks (power of two).
REQ-003 SHALL have parameter MEMORY_SIZE, default 262144, total size in bytes (multiple of 4*N_BANKS).
REQ-004 SHALL have parameter LATENCY, default 1, grant-to-r_valid delay in cycles (range 1..8).
REQ-005 SHALL have parameter STALL_THRESH, default 26, 8-bit stall threshold (26/256 ~ 0.1 stall probability).
REQ-006 SHALL have parameter SEED, default 16'hACE1, LFSR base seed.
REQ-007 SHALL have clk_i, input, 1, the single clock.
REQ-008 SHALL have rst_i, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have enable_i, input, 1, global grant enable.
REQ-010 SHALL have randomize_i and stallable_i, input, 1 each, both required high for stall injection.
REQ-011 SHALL have tcdm_req/tcdm_wen, input, [MP], request and write-enable (wen=0 write, wen=1 read).
REQ-012 SHALL have tcdm_add/tcdm_data, input, [MP][32], byte address and write data; tcdm_be, input, [MP][4].
REQ-013 SHALL have tcdm_gnt/tcdm_r_valid, output, [MP]; tcdm_r_data, output, [MP][32].
REQ-014 SHALL have cnt_rd_o/cnt_wr_o, output, [MP][32], per-port granted read and write counts.

Function
REQ-015 SHALL map each address to bank add[2 +: log2(N_BANKS)] and row add[31:2+log2(N_BANKS)] modulo rows-per-bank; out-of-range addresses wrap, no error.
REQ-016 SHALL store contents in a word array named memory, indexed by add[31:2] modulo MEMORY_SIZE/4, loadable hierarchically by the bench.
REQ-017 SHALL drive tcdm_gnt combinationally in the request cycle; at most one grant per bank per cycle.
REQ-018 SHALL arbitrate per bank round-robin; after a grant to port p, that bank's pointer moves to p+1 mod MP.
REQ-019 SHALL grant nothing while enable_i=0; requests stay pending with no side effects.
REQ-020 SHALL perform a granted write at the clock edge ending the grant cycle, updating only bytes with be=1.
REQ-021 SHALL sample read data at the clock edge ending the grant cycle, so a write granted the previous cycle is visible.
REQ-022 SHALL assert tcdm_r_valid for exactly one cycle, exactly LATENCY cycles after each grant, for reads and writes; r_data is the read word for reads and 0 for writes and idle cycles.
REQ-023 SHALL keep per-port response pipelines independent; back-to-back grants yield back-to-back r_valid with no loss.
REQ-024 SHALL increment cnt_rd_o[p] or cnt_wr_o[p] on each grant to port p, saturating at 32'hFFFFFFFF.
REQ-025 SHALL treat tcdm_add/data/be/wen as don't-care while req=0.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, clear all outputs, counters, response pipelines and round-robin pointers (to port 0), and reseed every LFSR.
REQ-027 SHALL drop in-flight responses when reset is asserted mid-operation; no r_valid for them follows reset.
REQ-028 SHALL leave memory contents unchanged by reset.

Configuration
REQ-029 SHALL compile stall injection only when macro TCDM_MODEL_STALL_EN is defined: per-port 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded SEED+p, advancing every cycle; port p is not granted in a cycle where randomize_i & stallable_i and LFSR[7:0] < STALL_THRESH.
REQ-030 SHALL, without TCDM_MODEL_STALL_EN, contain no LFSR logic and grant purely from enable_i and arbitration; randomize_i and stallable_i are ignored.

Verification
REQ-031 SHALL pass: port 0 writes 0xDEADBEEF to 0x100 (be=4'hF), then reads 0x100 -> gnt same cycle, r_valid LATENCY cycles later, r_data=0xDEADBEEF.
REQ-032 SHALL pass: be=4'b0101 write of 0x11223344 over 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-033 SHALL pass: ports 0,1,2 read bank 0 continuously for 6 cycles -> grants rotate 0,1,2,0,1,2; one grant per cycle.
REQ-034 SHALL pass: ports 0..3 read addresses 0x0,0x4,0x8,0xC in one cycle (N_BANKS=4) -> all four granted same cycle.
REQ-035 SHALL pass: reset asserted the cycle after a grant with LATENCY=3 -> no r_valid appears, counters read 0, memory intact.
REQ-036 SHALL pass: with TCDM_MODEL_STALL_EN, STALL_THRESH=26, randomize_i=stallable_i=1, 10000 requests on port 0 -> stalled fraction 0.08..0.12; with randomize_i=0 -> zero stalls.
